// File: rtl/fnd_scan_rx.sv
// Readback decoder for the multiplexed 7-segment scan bus; publishes MM:SS after a clean in-order 6-digit frame.
// Latency: inputs registered once, digit captured SETTLE_CYC edges after the sample register changes; frame pulse on the digit-5 capture edge.
// Backpressure: none; a pure observer of the bus, it never stalls the scanner and drops frames it cannot validate.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   i_seg_enb        active-low digit enables (one-hot-low when valid), bit n = digit n
//   i_seg, i_seg_dp  segments {a..g} and decimal point of the enabled digit
//   o_digit_seg      raw captured segments, digit n at [7n+6:7n]
//   o_six_dp         captured decimal point per digit
//   o_digit_num      decoded value per digit (E = blank, F = illegal), digit n at [4n+3:4n]
//   o_min, o_sec     digit3*10+digit2 and digit1*10+digit0 from the last good frame
//   o_frame_vld      one-cycle pulse when a good frame completes
//   o_err            one-cycle pulse when a bad frame completes
module fnd_scan_rx #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic [5:0]  i_seg_enb,
  output logic [41:0] o_digit_seg,
  output logic [5:0]  o_six_dp,
  output logic [23:0] o_digit_num,
  output logic [5:0]  o_min,
  output logic [5:0]  o_sec,
  output logic        o_frame_vld,
  output logic        o_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [5:0] ENB_IDLE = 6'h3f;

  // Inverse of the scanner's BCD-to-segment decoder.
  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    logic [3:0] num;
    case (seg)
      7'b1111110: num = 4'd0;
      7'b0110000: num = 4'd1;
      7'b1101101: num = 4'd2;
      7'b1111001: num = 4'd3;
      7'b0110011: num = 4'd4;
      7'b1011011: num = 4'd5;
      7'b1011111: num = 4'd6;
      7'b1110000: num = 4'd7;
      7'b1111111: num = 4'd8;
      7'b1110011: num = 4'd9;
      7'b0000000: num = 4'hE;
      default:    num = 4'hF;
    endcase
    return num;
  endfunction

  // ---------------------------------------------------------------
  // Input sample register: {enb[5:0], seg[6:0], dp}
  // ---------------------------------------------------------------
  logic [13:0] smp_q;
  logic [13:0] smp_d;
  logic        smp_chg;

  assign smp_d   = {i_seg_enb, i_seg, i_seg_dp};
  assign smp_chg = (smp_d != smp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= '0;
    end else begin
      smp_q <= smp_d;
    end
  end

  // ---------------------------------------------------------------
  // Stability FSM
  // ---------------------------------------------------------------
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (smp_chg) begin
      // A new bus value restarts settling; an all-high enable bus is blank time.
      cnt_d   = '0;
      state_d = (smp_d[13:8] == ENB_IDLE) ? IDLE : SETTLE;
    end else begin
      case (state_q)
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            capture = 1'b1;
            state_d = HELD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          // IDLE and HELD wait for the next bus change.
        end
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Capture decode (capture only fires when smp is unchanged, so smp_q
  // already holds the settled value)
  // ---------------------------------------------------------------
  logic [5:0] cap_enb_low;
  logic       cap_onehot;
  logic [2:0] cap_idx;
  logic [6:0] cap_seg;
  logic       cap_dp;
  logic [3:0] cap_num;
  logic       cap_num_bad;

  assign cap_enb_low = ~smp_q[13:8];
  assign cap_seg     = smp_q[7:1];
  assign cap_dp      = smp_q[0];
  assign cap_num     = seg_decode(cap_seg);
  assign cap_num_bad = (cap_num >= 4'hE) && (cap_idx <= 3'd3);
  assign cap_onehot  = (cap_enb_low != 6'd0) &&
                       ((cap_enb_low & (cap_enb_low - 6'd1)) == 6'd0);

  always_comb begin
    cap_idx = 3'd0;
    for (int n = 0; n < 6; n++) begin
      if (cap_enb_low[n]) begin
        cap_idx = 3'(n);
      end
    end
  end

  // ---------------------------------------------------------------
  // Digit storage and frame tracker
  // ---------------------------------------------------------------
  logic [41:0] digit_seg_q, digit_seg_d;
  logic [5:0]  six_dp_q, six_dp_d;
  logic [23:0] digit_num_q, digit_num_d;
  logic [2:0]  next_idx_q, next_idx_d;
  logic        bad_q, bad_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;

  logic        digit_wr;
  logic        frame_bad;
  logic [6:0]  min_sum;
  logic [6:0]  sec_sum;

  // Digits 0-3 are already in storage when digit 5 closes the frame.
  // Sums are formed at 7 bits and truncated; they are only published for
  // frames whose tens digits are 0-5, so the result always fits.
  assign min_sum = 7'(digit_num_q[15:12]) * 7'd10 + 7'(digit_num_q[11:8]);
  assign sec_sum = 7'(digit_num_q[7:4])   * 7'd10 + 7'(digit_num_q[3:0]);

  assign digit_wr  = capture && cap_onehot;
  // Digit 5 itself is never value-checked, only the accumulated flag and tens.
  assign frame_bad = bad_q ||
                     (digit_num_q[7:4]   > 4'd5) ||
                     (digit_num_q[15:12] > 4'd5);

  always_comb begin
    digit_seg_d = digit_seg_q;
    six_dp_d    = six_dp_q;
    digit_num_d = digit_num_q;
    next_idx_d  = next_idx_q;
    bad_d       = bad_q;
    min_d       = min_q;
    sec_d       = sec_q;
    vld_d       = 1'b0;
    err_d       = 1'b0;

    for (int n = 0; n < 6; n++) begin
      if (digit_wr && (cap_idx == 3'(n))) begin
        digit_seg_d[7*n +: 7] = cap_seg;
        six_dp_d[n]           = cap_dp;
        digit_num_d[4*n +: 4] = cap_num;
      end
    end

    if (capture) begin
      if (!cap_onehot) begin
        // Several digits driven at once: poison the frame, store nothing.
        bad_d = 1'b1;
      end else if (cap_idx == 3'd0) begin
        // Digit 0 always starts a fresh frame, in order or not.
        next_idx_d = 3'd1;
        bad_d      = cap_num_bad;
      end else if (cap_idx == next_idx_q) begin
        if (cap_idx == 3'd5) begin
          next_idx_d = 3'd0;
          bad_d      = 1'b0;
          if (frame_bad) begin
            err_d = 1'b1;
          end else begin
            vld_d = 1'b1;
            min_d = min_sum[5:0];
            sec_d = sec_sum[5:0];
          end
        end else begin
          next_idx_d = next_idx_q + 3'd1;
          bad_d      = bad_q || cap_num_bad;
        end
      end else begin
        // Out of order: discard the partial frame without reporting.
        next_idx_d = 3'd0;
        bad_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_seg_q <= '0;
      six_dp_q    <= '0;
      digit_num_q <= '0;
      next_idx_q  <= '0;
      bad_q       <= 1'b0;
      min_q       <= '0;
      sec_q       <= '0;
      vld_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      digit_seg_q <= digit_seg_d;
      six_dp_q    <= six_dp_d;
      digit_num_q <= digit_num_d;
      next_idx_q  <= next_idx_d;
      bad_q       <= bad_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      vld_q       <= vld_d;
      err_q       <= err_d;
    end
  end

  assign o_digit_seg = digit_seg_q;
  assign o_six_dp    = six_dp_q;
  assign o_digit_num = digit_num_q;
  assign o_min       = min_q;
  assign o_sec       = sec_q;
  assign o_frame_vld = vld_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_fnd_scan_rx.sv
// Bench for fnd_scan_rx: directed test-plan scenarios plus random scan traffic.
// Expected frame outcomes are queued by a reference model as stimulus is issued;
// a monitor pops and compares whenever the DUT pulses o_frame_vld or o_err.
module tb_fnd_scan_rx;

  localparam int SC = 4;

  localparam logic [6:0] SEGTAB [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011
  };
  localparam logic [6:0] BLANK = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  i_seg;
  logic        i_seg_dp;
  logic [5:0]  i_seg_enb;
  logic [41:0] o_digit_seg;
  logic [5:0]  o_six_dp;
  logic [23:0] o_digit_num;
  logic [5:0]  o_min;
  logic [5:0]  o_sec;
  logic        o_frame_vld;
  logic        o_err;

  always #10 clk = ~clk;

  fnd_scan_rx #(.SETTLE_CYC(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_seg       (i_seg),
    .i_seg_dp    (i_seg_dp),
    .i_seg_enb   (i_seg_enb),
    .o_digit_seg (o_digit_seg),
    .o_six_dp    (o_six_dp),
    .o_digit_num (o_digit_num),
    .o_min       (o_min),
    .o_sec       (o_sec),
    .o_frame_vld (o_frame_vld),
    .o_err       (o_err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        err;
    logic [5:0]  min;
    logic [5:0]  sec;
    logic [15:0] nums;
  } exp_t;
  exp_t expq[$];

  // Reference model state
  logic [3:0]  m_dig [6];
  int          m_pos;
  logic        m_bad;
  logic [5:0]  m_min, m_sec;
  logic [13:0] r_val;
  logic        r_valid;
  int          r_len;
  logic        r_cap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] seg_dec(input logic [6:0] s);
    if (s == BLANK) return 4'hE;
    for (int n = 0; n < 10; n++) begin
      if (SEGTAB[n] == s) return 4'(n);
    end
    return 4'hF;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 6; n++) m_dig[n] = 4'd0;
    m_pos   = 0;
    m_bad   = 1'b0;
    m_min   = 6'd0;
    m_sec   = 6'd0;
    r_valid = 1'b0;
    r_len   = 0;
    r_cap   = 1'b0;
  endtask

  // A settled digit: frame rules applied to the sequence of captured indices.
  task automatic model_capture(input logic [5:0] enb, input logic [6:0] seg);
    int   lows;
    int   idx;
    exp_t e;
    lows = 0;
    idx  = 0;
    for (int n = 0; n < 6; n++) begin
      if (!enb[n]) begin
        lows++;
        idx = n;
      end
    end
    if (lows > 1) begin
      m_bad = 1'b1;
      return;
    end
    m_dig[idx] = seg_dec(seg);
    if (idx == 0) begin
      m_pos = 1;
      m_bad = (m_dig[0] > 4'd9);
    end else if (idx == m_pos) begin
      if (idx <= 3 && m_dig[idx] > 4'd9) m_bad = 1'b1;
      if (idx == 5) begin
        if (m_dig[1] > 4'd5 || m_dig[3] > 4'd5) m_bad = 1'b1;
        if (!m_bad) begin
          m_min = 6'(int'(m_dig[3]) * 10 + int'(m_dig[2]));
          m_sec = 6'(int'(m_dig[1]) * 10 + int'(m_dig[0]));
        end
        e.err  = m_bad;
        e.min  = m_min;
        e.sec  = m_sec;
        e.nums = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        expq.push_back(e);
        m_pos = 0;
        m_bad = 1'b0;
      end else begin
        m_pos++;
      end
    end else begin
      m_pos = 0;
      m_bad = 1'b0;
    end
  endtask

  // Drive a bus value for len clock edges. A value is captured once it has
  // been presented for SC+1 consecutive edges (merged across repeated calls).
  task automatic hold(input logic [5:0] enb, input logic [6:0] seg, input logic dp, input int len);
    logic [13:0] v;
    v = {enb, seg, dp};
    if (!(r_valid && v == r_val)) begin
      r_val   = v;
      r_valid = 1'b1;
      r_len   = 0;
      r_cap   = 1'b0;
    end
    i_seg_enb = enb;
    i_seg     = seg;
    i_seg_dp  = dp;
    if (!r_cap && enb != 6'h3f && r_len + len >= SC + 1) begin
      r_cap = 1'b1;
      model_capture(enb, seg);
    end
    r_len += len;
    repeat (len) @(negedge clk);
  endtask

  task automatic frame(input logic [6:0] s0, s1, s2, s3, s4, s5, input int len);
    hold(6'b111110, s0, 1'b0, len);
    hold(6'b111101, s1, 1'b0, len);
    hold(6'b111011, s2, 1'b0, len);
    hold(6'b110111, s3, 1'b0, len);
    hold(6'b101111, s4, 1'b0, len);
    hold(6'b011111, s5, 1'b0, len);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle a pulse is present must match the next queued frame.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && (o_frame_vld || o_err)) begin
      if (o_frame_vld && o_err) begin
        total++;
        bad++;
        $display("FAIL pulse_exclusive: vld=%0b err=%0b both high at %0t", o_frame_vld, o_err, $time);
      end
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: vld=%0b err=%0b with no frame expected at %0t",
                 o_frame_vld, o_err, $time);
      end else begin
        e = expq.pop_front();
        chk("pulse_err", {31'd0, o_err}, {31'd0, e.err});
        chk("pulse_vld", {31'd0, o_frame_vld}, {31'd0, ~e.err});
        chk("frame_min", {26'd0, o_min}, {26'd0, e.min});
        chk("frame_sec", {26'd0, o_sec}, {26'd0, e.sec});
        chk("frame_nums", {16'd0, o_digit_num[15:0]}, {16'd0, e.nums});
      end
    end
  end

  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S1 = 7'b0110000;

  initial begin
    logic [6:0] segs [6];
    int         len;
    int         r;

    i_seg_enb = 6'h3f;
    i_seg     = BLANK;
    i_seg_dp  = 1'b0;
    rst_n     = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_digit_seg", {22'd0, o_digit_seg[41:32]}, 32'd0);
    chk("rst_digit_seg_lo", o_digit_seg[31:0], 32'd0);
    chk("rst_digit_num", {8'd0, o_digit_num}, 32'd0);
    chk("rst_dp_min_sec", {14'd0, o_six_dp, o_min, o_sec}, 32'd0);
    chk("rst_pulses", {30'd0, o_frame_vld, o_err}, 32'd0);
    hold(6'h3f, BLANK, 1'b0, 5);

    // Good frame: 12:34
    frame(S4, S3, S2, S1, BLANK, BLANK, 20);
    chk("good_min", {26'd0, o_min}, 32'd12);
    chk("good_sec", {26'd0, o_sec}, 32'd34);
    chk("good_nums", {16'd0, o_digit_num[15:0]}, 32'h1234);

    // Latency: new digit-2 value shows after exactly SC edges past the sample edge
    hold(6'b111011, 7'b1111111, 1'b0, 1);
    for (int j = 1; j <= SC; j++) begin
      chk("lat_before", {25'd0, o_digit_seg[20:14]}, {25'd0, S2});
      hold(6'b111011, 7'b1111111, 1'b0, 1);
    end
    chk("lat_after", {25'd0, o_digit_seg[20:14]}, {25'd0, 7'b1111111});

    // Glitch of SC cycles on digit 1 between digit-0 periods: not captured
    hold(6'b111110, S4, 1'b0, 20);
    hold(6'b111101, 7'b1111111, 1'b0, SC);
    hold(6'b111110, S4, 1'b0, 20);
    chk("glitch_seg1", {25'd0, o_digit_seg[13:7]}, {25'd0, S3});

    // Bad pattern in digit 1
    frame(S4, 7'b1000000, S2, S1, BLANK, BLANK, 20);
    chk("badpat_num1", {28'd0, o_digit_num[7:4]}, 32'hF);
    chk("badpat_min", {26'd0, o_min}, 32'd12);
    chk("badpat_sec", {26'd0, o_sec}, 32'd34);

    // Out of order 0,1,3,4,5: no pulse; then a full frame (05:27)
    hold(6'b111110, SEGTAB[7], 1'b0, 15);
    hold(6'b111101, SEGTAB[2], 1'b0, 15);
    hold(6'b110111, SEGTAB[0], 1'b0, 15);
    hold(6'b101111, BLANK, 1'b0, 15);
    hold(6'b011111, BLANK, 1'b0, 15);
    chk("order_min_held", {26'd0, o_min}, 32'd12);
    frame(SEGTAB[7], SEGTAB[2], SEGTAB[5], SEGTAB[0], BLANK, BLANK, 15);
    chk("order_min", {26'd0, o_min}, 32'd5);
    chk("order_sec", {26'd0, o_sec}, 32'd27);

    // Two enables low inside a frame
    hold(6'b111110, S4, 1'b0, 12);
    hold(6'b111101, S3, 1'b0, 12);
    hold(6'b111011, S2, 1'b0, 12);
    hold(6'b111100, 7'b1111111, 1'b0, 10);
    hold(6'b110111, S1, 1'b0, 12);
    hold(6'b101111, BLANK, 1'b0, 12);
    hold(6'b011111, BLANK, 1'b0, 12);
    chk("multi_min_held", {26'd0, o_min}, 32'd5);

    // Tens digit 7 in minutes
    frame(S4, S3, S2, SEGTAB[7], BLANK, BLANK, 12);
    chk("tens_min_held", {26'd0, o_min}, 32'd5);
    chk("tens_sec_held", {26'd0, o_sec}, 32'd27);

    // Reset after digit 3, then digits 4,5 only
    frame(S4, S3, S2, S1, BLANK, BLANK, 12);
    hold(6'b111110, SEGTAB[9], 1'b1, 12);
    hold(6'b111101, SEGTAB[1], 1'b0, 12);
    hold(6'b111011, SEGTAB[3], 1'b1, 12);
    hold(6'b110111, SEGTAB[2], 1'b0, 12);
    do_reset();
    hold(6'b101111, BLANK, 1'b0, 12);
    hold(6'b011111, BLANK, 1'b0, 12);
    chk("rstmid_min", {26'd0, o_min}, 32'd0);
    chk("rstmid_sec", {26'd0, o_sec}, 32'd0);
    chk("rstmid_nums", {16'd0, o_digit_num[15:0]}, 32'd0);
    chk("rstmid_seg_dp", {4'd0, o_digit_seg[27:0]} | {26'd0, o_six_dp}, 32'd0);
    frame(SEGTAB[9], SEGTAB[1], SEGTAB[3], SEGTAB[2], BLANK, BLANK, 12);
    chk("rstmid_after_min", {26'd0, o_min}, 32'd23);
    chk("rstmid_after_sec", {26'd0, o_sec}, 32'd19);

    // Random scan traffic
    for (int it = 0; it < 60; it++) begin
      for (int d = 0; d < 6; d++) begin
        r = int'($urandom_range(0, 99));
        if (d >= 4 && r < 50) segs[d] = BLANK;
        else if (r < 6)       segs[d] = 7'($urandom);
        else                  segs[d] = SEGTAB[$urandom_range(0, 9)];
      end
      for (int d = 0; d < 6; d++) begin
        r   = int'($urandom_range(0, 99));
        len = (r < 12) ? int'($urandom_range(1, SC + 1)) : int'($urandom_range(SC + 1, 14));
        if (r >= 12 && r < 16) continue;
        if (r >= 16 && r < 19) hold(6'($urandom) | 6'b110000, 7'($urandom), 1'($urandom), len);
        if (r >= 19 && r < 25) hold(6'h3f, BLANK, 1'b0, int'($urandom_range(1, 6)));
        hold(~(6'd1 << d), segs[d], 1'($urandom), len);
      end
    end

    hold(6'h3f, BLANK, 1'b0, 30);
    chk("queue_drained", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case anything stalls the stimulus process.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, stimulus did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
